// File: rtl/mult_div_pkg.sv
// mult_div_pkg
//   Shared definitions for the iterative multiply/divide unit.
//   - OP_* : operation encodings presented on the unit's op port.
//   - state_t : sequencer states (IDLE, RUN, FIX, ZDIV).
//   - op_is_div / op_is_signed : decode helpers for the op field.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZDIV = 2'd3
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// mult_div_sign_fix
//   Combinational sign correction applied to the magnitude results of the
//   iterative unit before they are written to HI/LO.
// Ports:
//   is_div  in   1      result came from a divide (else multiply)
//   neg_lo  in   1      negate product (multiply) or quotient (divide)
//   neg_hi  in   1      negate remainder (divide only)
//   raw_hi  in   WIDTH  magnitude product high half / remainder
//   raw_lo  in   WIDTH  magnitude product low half / quotient
//   fix_hi  out  WIDTH  signed-corrected HI value
//   fix_lo  out  WIDTH  signed-corrected LO value
module mult_div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic             neg_lo,
    input  logic             neg_hi,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_neg;

    // A product is negated as one 2*WIDTH quantity so the borrow crosses halves.
    assign prod_raw = {raw_hi, raw_lo};
    assign prod_neg = -prod_raw;

    always_comb begin
        fix_hi = raw_hi;
        fix_lo = raw_lo;
        if (is_div) begin
            if (neg_lo) fix_lo = -raw_lo;
            if (neg_hi) fix_hi = -raw_hi;
        end else if (neg_lo) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative MULT/MULTU/DIV/DIVU engine feeding the CPU's HI/LO registers.
//   Operands are reduced to magnitudes at start, processed one bit per clock
//   (shift-add multiply or restoring divide), then sign-corrected in FIX.
//   Optional build macro MULT_DIV_EARLY_EXIT_EN: multiplies leave RUN as soon
//   as the remaining multiplier bits are zero (variable latency, min 2).
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   WIDTH  multiplicand / dividend
//   b      in   WIDTH  multiplier / divisor
//   busy   out  1      operation in flight
//   done   out  1      one-cycle pulse, hi/lo (or div0) valid
//   div0   out  1      one-cycle pulse with done on divide by zero
//   hi     out  WIDTH  product high half / remainder
//   lo     out  WIDTH  product low half / quotient
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic take_abs);
        logic [WIDTH-1:0] m;
        m = $unsigned(v);
        if (take_abs && v[WIDTH-1]) m = $unsigned(-v);
        return m;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] counter_q;
    logic             load;
    logic             early_exit;

    logic             is_div_q;
    logic             neg_lo_q;
    logic             neg_hi_q;

    logic             signed_in;
    logic             is_div_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Multiply: acc_q is the running product, mcand_q the shifted multiplicand,
    // mplier_q the multiplier bits still to consume.
    // Divide:   acc_q is {remainder, dividend/quotient}, mcand_q[WIDTH-1:0] the divisor.
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic [WIDTH-1:0]   rem_next;
    logic               div_ge;

    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign signed_in = op_is_signed(op);
    assign is_div_in = op_is_div(op);
    assign mag_a     = magnitude($signed(a), signed_in);
    assign mag_b     = magnitude($signed(b), signed_in);

    // Restoring divide step: shift next dividend bit into the remainder and
    // subtract the divisor when it fits. rem_shift < 2*divisor, so a
    // successful subtraction always fits in WIDTH bits.
    assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff  = rem_shift[WIDTH-1:0] - mcand_q[WIDTH-1:0];
    assign div_ge    = rem_shift >= {1'b0, mcand_q[WIDTH-1:0]};
    assign rem_next  = div_ge ? rem_diff : rem_shift[WIDTH-1:0];

`ifdef MULT_DIV_EARLY_EXIT_EN
    // After the current step only mplier_q[WIDTH-1:1] remain to be consumed.
    assign early_exit = !is_div_q && (mplier_q[WIDTH-1:1] == '0);
`else
    assign early_exit = 1'b0;
`endif

    mult_div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_div (is_div_q),
        .neg_lo (neg_lo_q),
        .neg_hi (neg_hi_q),
        .raw_hi (acc_q[2*WIDTH-1:WIDTH]),
        .raw_lo (acc_q[WIDTH-1:0]),
        .fix_hi (fix_hi),
        .fix_lo (fix_lo)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (is_div_in && (b == '0)) ? ZDIV : RUN;
                end
            end
            RUN: begin
                if ((counter_q == LAST_CNT) || early_exit) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            ZDIV:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div0      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            div0    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        busy      <= 1'b1;
                        counter_q <= '0;
                        is_div_q  <= is_div_in;
                        neg_lo_q  <= signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_q  <= signed_in && is_div_in && a[WIDTH-1];
                    end
                end
                RUN: counter_q <= counter_q + CNT_W'(1);
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                end
                ZDIV: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    div0 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Iteration datapath
    always_ff @(posedge clk) begin
        if (load) begin
            acc_q    <= is_div_in ? {{WIDTH{1'b0}}, mag_a} : '0;
            mcand_q  <= is_div_in ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
        end else if (state_q == RUN) begin
            if (is_div_q) begin
                acc_q <= {rem_next, acc_q[WIDTH-2:0], div_ge};
            end else begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit that drives the HI/LO registers of the multicycle CPU.
- Executes MULT, MULTU, DIV and DIVU over WIDTH-bit operands, one bit per clock.
- Handshake: start/busy/done, plus a divide-by-zero flag that feeds the control unit's DIV0 exception path.
- The control unit asserts start with A/B register contents and write-enables HI/LO on done.

Parameters:
- WIDTH, 32: operand width and width of each result half.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low (0 = reset).
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse; hi/lo (or div0) valid.
- div0  output  1  one-cycle pulse with done on divide by zero.
- hi  output  WIDTH  product high half / remainder.
- lo  output  WIDTH  product low half / quotient.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE.
  - busy=0, done=0, div0=0, hi=0, lo=0, counter=0.
- States:
  - IDLE: wait for start.
  - RUN: shift-add multiply or restoring divide on magnitudes, one bit per cycle.
  - FIX: sign correction, write hi/lo, pulse done.
  - ZDIV: divide-by-zero completion.
- IDLE, start=1 at edge E0:
  - Latch op, |a|, |b| (signed ops only; unsigned ops take raw values) and the result sign bits.
  - counter=0, busy=1.
  - If op is DIV/DIVU and b==0: go to ZDIV; otherwise go to RUN.
- RUN: counter increments each edge; after WIDTH iterations (edges E1..E_WIDTH) go to FIX.
- FIX, edge E_WIDTH+1:
  - hi/lo updated, done=1 for exactly one cycle, busy=0, return to IDLE.
  - Latency from the start edge to done: WIDTH+1 cycles.
- ZDIV, edge E1: done=1, div0=1 for one cycle, busy=0, hi/lo unchanged, return to IDLE.
- start while busy: ignored; no queuing.
- start in the cycle done is high: accepted (state is already IDLE).
- hi/lo hold their value between completions; done and div0 are 0 outside their pulse.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV of most-negative by -1: lo=most-negative (wraps), hi=0; no flag raised.
  - Magnitude of the most-negative value is handled as an unsigned WIDTH-bit quantity; no overflow.
- op, a, b may change after the start edge without effect.
- Reset mid-operation aborts immediately to reset values; no done pulse.

Optional Feature:
- Macro: MULT_DIV_EARLY_EXIT_EN.
- Defined:
  - MULT/MULTU leave RUN as soon as the remaining multiplier bits are all zero; FIX follows on the next edge.
  - Multiply latency becomes variable, minimum 2 cycles; with b==0, done arrives 2 cycles after the start edge.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH+1 latency for all non-zero-divisor operations.

Decomposition:
- Package mult_div_pkg:
  - op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - state enum (IDLE, RUN, FIX, ZDIV).
- Sub-module mult_div_sign_fix (combinational):
  - Inputs: raw magnitude results and sign flags.
  - Outputs: corrected hi/lo. Instantiated once in FIX.
- Iteration datapath stays in the parent.

Test Plan (WIDTH=32, macro undefined):
- MULT a=-3, b=7 -> done 33 cycles after start; hi=FFFFFFFF, lo=FFFFFFEB; busy high for 33 cycles.
- DIVU a=100, b=7 -> lo=0000000E, hi=00000002. DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div0=0.
- After MULTU 5*6 completes (hi=0, lo=1E), DIV b=0 -> done and div0 high together 1 cycle after start; hi/lo still 0/1E.
- During a DIV: pulse start with new operands at cycle 10 -> ignored, original result delivered. Assert reset at cycle 20 of a later op -> busy=0, hi=lo=0, no done.
- Macro defined: MULTU a=9, b=1 -> done 2 cycles after start, lo=9. MULTU b=80000000 -> done 33 cycles after start.
